int_ctrl_unit: RTL and testbench
================================

// Module: int_ctrl_unit
// PURPOSE
//  Interrupt control unit (ICU). Sequences the pipeline when an external interrupt
//  arrives: drains in-flight work, pushes the return PC (and optionally flags) through
//  the stack datapath, fetches the ISR vector from data memory, and redirects the PC.
//  While busy it owns the stack/memory/ALU control lines that the decode CU releases
//  whenever int_flag is high.
// PARAMETERS
//  PC_WIDTH      32  program counter width, always 2*DATA_WIDTH
//  DATA_WIDTH    16  data memory word width
//  VECTOR_ADDR   0   word address of the ISR vector: low word at VECTOR_ADDR, high word at +1
//  FLUSH_CYCLES  3   drain cycles before the first push; legal range 1..15
// PORTS
//  clk              in   1           rising-edge clock
//  rst              in   1           synchronous reset, active-high
//  int_req          in   1           external interrupt request, level input, edge-detected
//  mem_stall        in   1           data memory not ready; the FSM holds its state
//  pc_in            in   PC_WIDTH    return PC, captured on entry to FLUSH
//  flags_in         in   4           CCR flags {V,C,N,Z}, captured with pc_in
//  mem_rdata        in   DATA_WIDTH  data memory read data, valid in the same cycle as DMR
//  int_flag         out  1           ICU owns the control lines; decode CU drives z
//  busy             out  1           FSM is not in IDLE
//  stack_operation  out  1           address is taken from SP
//  push_pop         out  1           1 = push, 0 = pop
//  write_sp         out  1           update SP this cycle
//  DMR              out  1           data memory read strobe
//  DMW              out  1           data memory write strobe
//  alu_function     out  4           4'b0100 (pass operand2) during pushes, else 4'b0000
//  mem_addr         out  DATA_WIDTH  absolute address used during vector reads
//  wdata            out  DATA_WIDTH  data to push
//  pc_out           out  PC_WIDTH    ISR entry address
//  pc_load          out  1           one-cycle strobe: load pc_out into PC
// BEHAVIOUR
//  - Reset: state IDLE, pending=0, captured regs=0. All outputs are 0 while rst is high and in IDLE.
//  - Pending latch: set on an int_req 0->1 edge. Cleared on entry to FLUSH.
//    Edges while pending or busy merge into a single pending bit; none are counted.
//  - Outputs are Moore-decoded from the state register only.
//    int_flag = busy = (state != IDLE).
//  - IDLE: if pending && !mem_stall -> FLUSH. Capture pc_in and flags_in, cnt = FLUSH_CYCLES-1.
//  - FLUSH: all strobes 0. Count down; at cnt == 0 -> PUSH_HI.
//  - PUSH_HI: wdata = pc[31:16]; DMW = stack_operation = push_pop = write_sp = 1;
//    alu_function = 0100 -> PUSH_LO.
//  - PUSH_LO: wdata = pc[15:0], same strobes -> PUSH_FL if ICU_PUSH_FLAGS_EN, else VEC_LO.
//  - VEC_LO: DMR = 1, mem_addr = VECTOR_ADDR; register mem_rdata into vec[15:0] -> VEC_HI.
//  - VEC_HI: DMR = 1, mem_addr = VECTOR_ADDR+1; register into vec[31:16] -> JUMP.
//  - JUMP: pc_out = vec, pc_load = 1 for exactly one cycle -> IDLE.
//  - mem_stall = 1 in any non-IDLE state except FLUSH: state and outputs are frozen.
//    Strobes stay asserted but write_sp takes effect once, on the releasing cycle.
//    FLUSH counts regardless of mem_stall.
//  - Nominal latency with no stall, edge seen at cycle 0: pending at cycle 1, FLUSH at 2,
//    pc_load at cycle 2+FLUSH_CYCLES+4 (+1 with flags).
//  - rst mid-sequence: immediate return to IDLE; partial pushes are not undone;
//    pending is cleared.
//  - A new edge during JUMP sets pending; the next sequence starts from IDLE
//    (at least 1 IDLE cycle between sequences).
// CONFIGURATION
//  ICU_PUSH_FLAGS_EN defined:
//    extra state PUSH_FL after PUSH_LO: wdata = {12'b0, flags}, same push strobes.
//    Total 3 pushes; RTI must pop 3 words.
//  ICU_PUSH_FLAGS_EN undefined:
//    PUSH_FL and the flags register are absent; flags_in is unused; 2 pushes.
// TESTING
//  1. rst=1 for 2 cycles, int_req=1 -> all outputs 0, busy=0; no sequence starts after release without a new edge.
//  2. pc_in=0x0001_2345, M[0]=0x0100, M[1]=0x0000, FLUSH_CYCLES=3 ->
//     pushes 0x0001 then 0x2345; pc_load with pc_out=0x0000_0100 at cycle 9.
//  3. mem_stall=1 for 4 cycles during PUSH_LO -> state held, wdata stays 0x2345,
//     write_sp applied once, pc_load delayed by 4 cycles.
//  4. Second int_req edge during VEC_HI -> current sequence completes, one IDLE cycle,
//     then exactly one more sequence; a third edge in the same window adds nothing.
//  5. rst pulsed during PUSH_HI -> IDLE next cycle, int_flag=0, pending=0, no pc_load.
//  6. ICU_PUSH_FLAGS_EN, flags_in=4'b1010 -> third push wdata=0x000A;
//     pc_load one cycle later than in test 2.

Source files
------------

// File: rtl/int_ctrl_unit_if.sv
// ----------------------------------------------------------------------------
// Module   : int_ctrl_unit_if
// Brief    : Request, stack/memory and PC-redirect signals of the interrupt control unit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface int_ctrl_unit_if #(
    parameter int PC_WIDTH   = 32,
    parameter int DATA_WIDTH = 16
);
    logic                  int_req;
    logic                  mem_stall;
    logic [PC_WIDTH-1:0]   pc_in;
    logic [3:0]            flags_in;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  int_flag;
    logic                  busy;
    logic                  stack_operation;
    logic                  push_pop;
    logic                  write_sp;
    logic                  DMR;
    logic                  DMW;
    logic [3:0]            alu_function;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [PC_WIDTH-1:0]   pc_out;
    logic                  pc_load;

    // master is the ICU itself; slave is the pipeline/memory side
    modport master (
        input  int_req, mem_stall, pc_in, flags_in, mem_rdata,
        output int_flag, busy, stack_operation, push_pop, write_sp, DMR, DMW,
               alu_function, mem_addr, wdata, pc_out, pc_load
    );

    modport slave (
        output int_req, mem_stall, pc_in, flags_in, mem_rdata,
        input  int_flag, busy, stack_operation, push_pop, write_sp, DMR, DMW,
               alu_function, mem_addr, wdata, pc_out, pc_load
    );
endinterface

`default_nettype wire

// File: rtl/int_ctrl_unit.sv
// ----------------------------------------------------------------------------
// Module   : int_ctrl_unit
// Brief    : Interrupt sequencer: drain, push return PC, fetch ISR vector, redirect PC.
//            Define ICU_PUSH_FLAGS_EN to also push the CCR flags as a third word.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module int_ctrl_unit #(
    parameter int PC_WIDTH     = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int VECTOR_ADDR  = 0,
    parameter int FLUSH_CYCLES = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    int_ctrl_unit_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLUSH   = 3'd1,
        S_PUSH_HI = 3'd2,
        S_PUSH_LO = 3'd3,
        S_VEC_LO  = 3'd4,
        S_VEC_HI  = 3'd5,
        S_JUMP    = 3'd6
`ifdef ICU_PUSH_FLAGS_EN
        , S_PUSH_FL = 3'd7
`endif
    } state_t;

    localparam logic [3:0]            c_flush_load = 4'(FLUSH_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] c_vec_lo     = DATA_WIDTH'(VECTOR_ADDR);
    localparam logic [DATA_WIDTH-1:0] c_vec_hi     = DATA_WIDTH'(VECTOR_ADDR + 1);
    localparam logic [3:0]            c_alu_pass2  = 4'b0100;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_req_d;
    logic                  r_pending;
    logic [3:0]            r_cnt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_vec;
    logic                  w_req_edge;
    logic                  w_enter_flush;
    logic                  w_push;

`ifdef ICU_PUSH_FLAGS_EN
    logic [3:0]            r_flags;
`else
    logic                  w_flags_unused;
    assign w_flags_unused = ^bus.flags_in;
`endif

    assign w_req_edge = bus.int_req & ~r_req_d;

    // The edge detector keeps tracking int_req through reset so a level held
    // high across reset release is not mistaken for a fresh request.
    always_ff @(posedge clk) begin
        r_req_d <= bus.int_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            r_cnt     <= 4'd0;
            r_pc      <= '0;
            r_vec     <= '0;
`ifdef ICU_PUSH_FLAGS_EN
            r_flags   <= 4'd0;
`endif
        end else begin
            r_state <= w_state_nxt;

            // An edge coinciding with FLUSH entry merges into the request being served.
            if (w_enter_flush) begin
                r_pending <= 1'b0;
            end else if (w_req_edge) begin
                r_pending <= 1'b1;
            end

            if (w_enter_flush) begin
                r_pc  <= bus.pc_in;
                r_cnt <= c_flush_load;
`ifdef ICU_PUSH_FLAGS_EN
                r_flags <= bus.flags_in;
`endif
            end else if (r_state == S_FLUSH && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (!bus.mem_stall) begin
                if (r_state == S_VEC_LO) begin
                    r_vec[DATA_WIDTH-1:0] <= bus.mem_rdata;
                end
                if (r_state == S_VEC_HI) begin
                    r_vec[PC_WIDTH-1:DATA_WIDTH] <= bus.mem_rdata;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_enter_flush = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending && !bus.mem_stall) begin
                    w_state_nxt   = S_FLUSH;
                    w_enter_flush = 1'b1;
                end
            end
            S_FLUSH: begin
                if (r_cnt == 4'd0) w_state_nxt = S_PUSH_HI;
            end
            S_PUSH_HI: begin
                if (!bus.mem_stall) w_state_nxt = S_PUSH_LO;
            end
            S_PUSH_LO: begin
`ifdef ICU_PUSH_FLAGS_EN
                if (!bus.mem_stall) w_state_nxt = S_PUSH_FL;
`else
                if (!bus.mem_stall) w_state_nxt = S_VEC_LO;
`endif
            end
`ifdef ICU_PUSH_FLAGS_EN
            S_PUSH_FL: begin
                if (!bus.mem_stall) w_state_nxt = S_VEC_LO;
            end
`endif
            S_VEC_LO: begin
                if (!bus.mem_stall) w_state_nxt = S_VEC_HI;
            end
            S_VEC_HI: begin
                if (!bus.mem_stall) w_state_nxt = S_JUMP;
            end
            S_JUMP: begin
                if (!bus.mem_stall) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef ICU_PUSH_FLAGS_EN
    assign w_push = (r_state == S_PUSH_HI) || (r_state == S_PUSH_LO) || (r_state == S_PUSH_FL);
`else
    assign w_push = (r_state == S_PUSH_HI) || (r_state == S_PUSH_LO);
`endif

    assign bus.int_flag        = (r_state != S_IDLE);
    assign bus.busy            = (r_state != S_IDLE);
    assign bus.stack_operation = w_push;
    assign bus.push_pop        = w_push;
    assign bus.write_sp        = w_push;
    assign bus.DMW             = w_push;
    assign bus.alu_function    = w_push ? c_alu_pass2 : 4'b0000;
    assign bus.DMR             = (r_state == S_VEC_LO) || (r_state == S_VEC_HI);
    assign bus.pc_load         = (r_state == S_JUMP);
    assign bus.pc_out          = (r_state == S_JUMP) ? r_vec : '0;

    always_comb begin
        bus.wdata    = '0;
        bus.mem_addr = '0;
        case (r_state)
            S_PUSH_HI: bus.wdata    = r_pc[PC_WIDTH-1:DATA_WIDTH];
            S_PUSH_LO: bus.wdata    = r_pc[DATA_WIDTH-1:0];
`ifdef ICU_PUSH_FLAGS_EN
            S_PUSH_FL: bus.wdata    = {{(DATA_WIDTH-4){1'b0}}, r_flags};
`endif
            S_VEC_LO:  bus.mem_addr = c_vec_lo;
            S_VEC_HI:  bus.mem_addr = c_vec_hi;
            default: begin
                bus.wdata    = '0;
                bus.mem_addr = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl_unit.sv
// ----------------------------------------------------------------------------
// Module   : tb_int_ctrl_unit
// Brief    : Self-checking bench for int_ctrl_unit against a step-list reference model.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_int_ctrl_unit;

    localparam int FLUSH = 3;
    localparam int VA    = 0;
`ifdef ICU_PUSH_FLAGS_EN
    localparam int N_PUSH = 3;
`else
    localparam int N_PUSH = 2;
`endif
    localparam int N_STEPS  = FLUSH + N_PUSH + 3;
    localparam int LAT_NOM  = 2 + FLUSH + 4 + (N_PUSH - 2);

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem [2];
    logic [15:0] junk;
    logic [15:0] pushes [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    // reference model: position in the ordered list of sequence steps
    bit          m_active, m_pending, m_prev_req;
    int          m_step;
    logic [31:0] m_pc;
    logic [3:0]  m_flags;

    int_ctrl_unit_if #(.PC_WIDTH(32), .DATA_WIDTH(16)) bus ();

    int_ctrl_unit #(
        .PC_WIDTH(32), .DATA_WIDTH(16), .VECTOR_ADDR(VA), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = (bus.DMR && !bus.mem_stall)
                         ? ((bus.mem_addr == 16'(VA)) ? mem[0] : mem[1]) : junk;

    task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [75:0] pack_dut();
        return {bus.int_flag, bus.busy, bus.stack_operation, bus.push_pop, bus.write_sp,
                bus.DMR, bus.DMW, bus.alu_function, bus.mem_addr, bus.wdata,
                bus.pc_out, bus.pc_load};
    endfunction

    function automatic logic [75:0] exp_out();
        logic        push, rd, ld;
        logic [15:0] addr, data;
        logic [31:0] pco;
        int          k;
        push = 0; rd = 0; ld = 0; addr = 0; data = 0; pco = 0;
        if (!m_active) return '0;
        if (m_step >= FLUSH && m_step < FLUSH + N_PUSH) begin
            k    = m_step - FLUSH;
            push = 1;
            data = (k == 0) ? m_pc[31:16] : (k == 1) ? m_pc[15:0] : {12'b0, m_flags};
        end else if (m_step >= FLUSH + N_PUSH && m_step < FLUSH + N_PUSH + 2) begin
            rd   = 1;
            addr = 16'(VA + m_step - FLUSH - N_PUSH);
        end else if (m_step == N_STEPS - 1) begin
            ld  = 1;
            pco = {mem[1], mem[0]};
        end
        return {1'b1, 1'b1, push, push, push, rd, push, (push ? 4'b0100 : 4'b0000),
                addr, data, pco, ld};
    endfunction

    task automatic model_update();
        bit edge_seen, start;
        edge_seen  = bus.int_req && !m_prev_req;
        m_prev_req = bus.int_req;
        if (rst) begin
            m_active = 0; m_pending = 0; m_step = 0;
            return;
        end
        start = !m_active && m_pending && !bus.mem_stall;
        if (m_active && (m_step < FLUSH || !bus.mem_stall)) begin
            if (m_step == N_STEPS - 1) m_active = 0;
            else m_step++;
        end
        if (start) begin
            m_active = 1; m_step = 0; m_pc = bus.pc_in; m_flags = bus.flags_in;
        end
        m_pending = start ? 1'b0 : (m_pending || edge_seen);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        check("outputs", pack_dut(), exp_out());
        junk = 16'($urandom);
    endtask

    // Raises one request edge and runs until pc_load, optionally stalling a window.
    task automatic run_to_load(input int maxc, input int stall_at, input int stall_len,
                               output int lat, output logic [31:0] pc, output int nsp);
        lat = 0; pc = 0; nsp = 0;
        bus.int_req = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            bus.mem_stall = (lat >= stall_at && lat < stall_at + stall_len);
            if (bus.write_sp && !bus.mem_stall) nsp++;
            if (bus.DMW && !bus.mem_stall) pushes.push_back(bus.wdata);
            tick();
            lat++;
            if (i == 0) bus.int_req = 1'b0;
            if (bus.pc_load) begin
                pc = bus.pc_out;
                bus.mem_stall = 1'b0;
                return;
            end
        end
        bus.mem_stall = 1'b0;
        lat = -1;
    endtask

    function automatic logic [15:0] push_at(input int i);
        return (i < pushes.size()) ? pushes[i] : 16'hFFFF;
    endfunction

    initial begin
        int          lat, nsp, n_load, n_rise, ph, n_busy;
        logic [31:0] pc;
        bit          prev_busy;

        rst = 1'b1; bus.int_req = 1'b1; bus.mem_stall = 1'b0;
        bus.pc_in = '0; bus.flags_in = '0; junk = '0;
        mem[0] = 16'h0100; mem[1] = 16'h0000;
        m_active = 0; m_pending = 0; m_prev_req = 0; m_step = 0; m_pc = 0; m_flags = 0;

        // reset with int_req held high: nothing may start after release
        tick(); tick();
        check("rst_outputs", pack_dut(), 76'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("no_start_after_rst", {75'd0, bus.busy}, 76'd0);
        bus.int_req = 1'b0;
        tick();

        // nominal sequence
        pushes.delete();
        bus.pc_in = 32'h0001_2345; bus.flags_in = 4'b1010;
        run_to_load(40, 1000, 0, lat, pc, nsp);
        check("nominal_latency", 76'(lat), 76'(LAT_NOM));
        check("nominal_pc_out", 76'(pc), 76'h0000_0100);
        check("nominal_npush", 76'(pushes.size()), 76'(N_PUSH));
        check("push_pc_hi", 76'(push_at(0)), 76'h0001);
        check("push_pc_lo", 76'(push_at(1)), 76'h2345);
`ifdef ICU_PUSH_FLAGS_EN
        check("push_flags", 76'(push_at(2)), 76'h000A);
`endif
        check("nominal_sp_writes", 76'(nsp), 76'(N_PUSH));
        tick(); tick();

        // 4-cycle stall while PUSH_LO is presented (cycle 6)
        pushes.delete();
        run_to_load(40, 6, 4, lat, pc, nsp);
        check("stall_latency", 76'(lat), 76'(LAT_NOM + 4));
        check("stall_sp_writes", 76'(nsp), 76'(N_PUSH));
        check("stall_push_lo", 76'(push_at(1)), 76'h2345);
        tick(); tick();

        // second edge in VEC_HI, third at the IDLE->FLUSH hand-off
        bus.int_req = 1'b1; tick(); bus.int_req = 1'b0;
        n_load = 0; n_rise = 0; prev_busy = 0; ph = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.busy && !prev_busy) n_rise++;
            prev_busy = bus.busy;
            if (bus.pc_load) n_load++;
            case (ph)
                0: if (bus.DMR && bus.mem_addr == 16'(VA + 1)) begin bus.int_req = 1'b1; ph = 1; end
                1: begin bus.int_req = 1'b0; ph = 2; end
                2: begin bus.int_req = 1'b1; ph = 3; end
                3: begin bus.int_req = 1'b0; ph = 4; end
                default: ;
            endcase
        end
        check("merge_loads", 76'(n_load), 76'd2);
        check("merge_sequences", 76'(n_rise), 76'd2);

        // reset during PUSH_HI with another request already pending
        bus.pc_in = 32'hCAFE_0042;
        bus.int_req = 1'b1; tick(); bus.int_req = 1'b0;
        tick(); tick();
        bus.int_req = 1'b1; tick(); bus.int_req = 1'b0;
        for (int i = 0; i < 12 && !bus.DMW; i++) tick();
        check("rst_mid_in_push_hi", 76'(bus.wdata), 76'hCAFE);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_int_flag", {75'd0, bus.int_flag}, 76'd0);
        n_load = 0; n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.pc_load) n_load++;
            if (bus.busy) n_busy++;
        end
        check("rst_mid_no_load", 76'(n_load), 76'd0);
        check("rst_mid_pending_clear", 76'(n_busy), 76'd0);

        // randomized traffic against the model
        mem[0] = 16'($urandom); mem[1] = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) bus.int_req = ~bus.int_req;
            bus.mem_stall = ($urandom_range(4) == 0);
            rst           = ($urandom_range(299) == 0);
            bus.pc_in     = $urandom;
            bus.flags_in  = 4'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
